// File: rtl/wf_done_arbiter.sv
// -----------------------------------------------------------------------------
// wf_done_arbiter
//
// Serialises per-CU wavefront-completion pulses into one valid/ready stream
// for the dispatcher's deallocation path.
//
// Each CU owns a one-entry holding slot (valid bit + tag). A round-robin
// scheduler, starting its scan at rr_ptr_q, picks one occupied slot whenever
// the registered output stage is free and moves that slot's tag and index
// into the output register. A slot that is being drained can recapture a new
// pulse on the same edge, so a CU may complete one wavefront per cycle
// without loss.
//
// Optional feature macro: WF_DONE_ARB_OVF_CHECK_EN
//   defined   : a pulse that hits an occupied, non-draining slot sets the
//               sticky arb_overflow flag (cleared only by reset).
//   undefined : overflow logic is absent and arb_overflow is tied to 0.
//   Drop behaviour is identical in both builds.
//
// Ports
//   clk                     : clock, all state updates on the rising edge
//   rst                     : synchronous active-low reset (0 = reset)
//   cu2dispatch_wf_done     : one-cycle done pulse per CU
//   cu2dispatch_wf_tag_done : tag of CU k in bits [k*TAG_WIDTH +: TAG_WIDTH]
//   arb_done_valid          : completion available on the output
//   arb_done_cu_id          : CU that produced the completion
//   arb_done_tag            : completed wavefront tag
//   arb_done_ready          : consumer accepts when valid && ready
//   arb_slot_busy           : occupancy bit of each holding slot
//   arb_overflow            : sticky overflow flag
// -----------------------------------------------------------------------------
module wf_done_arbiter #(
    parameter int NUMBER_CU   = 8,
    parameter int CU_ID_WIDTH = 3,
    parameter int TAG_WIDTH   = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUMBER_CU-1:0]           cu2dispatch_wf_done,
    input  logic [NUMBER_CU*TAG_WIDTH-1:0] cu2dispatch_wf_tag_done,
    output logic                           arb_done_valid,
    output logic [CU_ID_WIDTH-1:0]         arb_done_cu_id,
    output logic [TAG_WIDTH-1:0]           arb_done_tag,
    input  logic                           arb_done_ready,
    output logic [NUMBER_CU-1:0]           arb_slot_busy,
    output logic                           arb_overflow
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } out_state_e;

    // Scan arithmetic is one bit wider than the CU index so the modulo
    // wrap works for any NUMBER_CU, power of two or not.
    localparam logic [CU_ID_WIDTH:0]   NCU_EXT = (CU_ID_WIDTH+1)'(NUMBER_CU);
    localparam logic [CU_ID_WIDTH-1:0] LAST_CU = CU_ID_WIDTH'(NUMBER_CU - 1);

    // Holding slots
    logic [NUMBER_CU-1:0] slot_valid_q;
    logic [NUMBER_CU-1:0] slot_valid_d;
    logic [TAG_WIDTH-1:0] slot_tag_q [NUMBER_CU];
    logic [TAG_WIDTH-1:0] slot_tag_d [NUMBER_CU];

    // Scheduler and output stage
    logic [CU_ID_WIDTH-1:0] rr_ptr_q;
    logic [CU_ID_WIDTH-1:0] rr_ptr_d;
    out_state_e             state_q;
    out_state_e             state_d;
    logic [CU_ID_WIDTH-1:0] cu_id_q;
    logic [CU_ID_WIDTH-1:0] cu_id_d;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [TAG_WIDTH-1:0]   tag_d;

    // Combinational helpers
    logic                   stage_free_s;
    logic                   grant_vld_s;
    logic [CU_ID_WIDTH-1:0] grant_idx_s;
    logic [CU_ID_WIDTH:0]   cand_s;
    logic                   take_s;
    logic [NUMBER_CU-1:0]   grant_oh_s;

    // Round-robin search: first occupied slot at or after rr_ptr_q, with wrap.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int i = 0; i < NUMBER_CU; i++) begin
            cand_s = {1'b0, rr_ptr_q} + (CU_ID_WIDTH+1)'(i);
            if (cand_s >= NCU_EXT) begin
                cand_s = cand_s - NCU_EXT;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_vld_s && slot_valid_q[cand_s[CU_ID_WIDTH-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s[CU_ID_WIDTH-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // A grant only takes effect when the output register can accept new data.
    always_comb begin
        stage_free_s = (state_q == S_IDLE) || arb_done_ready;
        take_s       = stage_free_s && grant_vld_s;
        grant_oh_s   = '0;
        for (int k = 0; k < NUMBER_CU; k++) begin
            grant_oh_s[k] = take_s && (grant_idx_s == CU_ID_WIDTH'(k));
        end
    end

    // Slot next-state: capture into empty or draining slots, otherwise drop.
    always_comb begin
        slot_valid_d = slot_valid_q;
        for (int k = 0; k < NUMBER_CU; k++) begin
            slot_tag_d[k] = slot_tag_q[k];
            if (cu2dispatch_wf_done[k]) begin
                if (!slot_valid_q[k] || grant_oh_s[k]) begin
                    // Recapture on the drain edge keeps the slot valid with the new tag.
                    slot_valid_d[k] = 1'b1;
                    slot_tag_d[k]   = cu2dispatch_wf_tag_done[k*TAG_WIDTH +: TAG_WIDTH];
                end else begin
                    // Occupied and not draining: the stored tag wins.
                    slot_valid_d[k] = slot_valid_q[k];
                end
            end else if (grant_oh_s[k]) begin
                slot_valid_d[k] = 1'b0;
            end else begin
                slot_valid_d[k] = slot_valid_q[k];
            end
        end
    end

    // Output stage and round-robin pointer next-state.
    always_comb begin
        state_d  = state_q;
        cu_id_d  = cu_id_q;
        tag_d    = tag_q;
        rr_ptr_d = rr_ptr_q;
        if (stage_free_s) begin
            if (grant_vld_s) begin
                state_d = S_HOLD;
                cu_id_d = grant_idx_s;
                tag_d   = slot_tag_q[grant_idx_s];
                if (grant_idx_s == LAST_CU) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx_s + CU_ID_WIDTH'(1);
                end
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            // Back-pressured: hold the presented completion stable.
            state_d = state_q;
        end
    end

    // State registers for slots, scheduler and output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_valid_q <= '0;
            for (int k = 0; k < NUMBER_CU; k++) begin
                slot_tag_q[k] <= '0;
            end
            rr_ptr_q <= '0;
            state_q  <= S_IDLE;
            cu_id_q  <= '0;
            tag_q    <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int k = 0; k < NUMBER_CU; k++) begin
                slot_tag_q[k] <= slot_tag_d[k];
            end
            rr_ptr_q <= rr_ptr_d;
            state_q  <= state_d;
            cu_id_q  <= cu_id_d;
            tag_q    <= tag_d;
        end
    end

`ifdef WF_DONE_ARB_OVF_CHECK_EN
    logic [NUMBER_CU-1:0] drop_s;
    logic                 ovf_q;
    logic                 ovf_d;

    // A pulse is dropped when its slot is occupied and not drained this edge.
    always_comb begin
        drop_s = cu2dispatch_wf_done & slot_valid_q & ~grant_oh_s;
        ovf_d  = ovf_q | (|drop_s);
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign arb_overflow = ovf_q;
`else
    assign arb_overflow = 1'b0;
`endif

    assign arb_done_valid = (state_q == S_HOLD);
    assign arb_done_cu_id = cu_id_q;
    assign arb_done_tag   = tag_q;
    assign arb_slot_busy  = slot_valid_q;

endmodule

// File: tb/tb_wf_done_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wf_done_arbiter
//
// Directed scenarios followed by randomized traffic. A behavioural model of
// the arbiter predicts every completion the DUT should produce and pushes it
// into an expected queue; an independent monitor compares each presented
// completion against the queue head and pops it on acceptance.
// -----------------------------------------------------------------------------
module tb_wf_done_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int TW = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    done;
    logic [N*TW-1:0] tags;
    logic            ready;
    logic            arb_done_valid;
    logic [IW-1:0]   arb_done_cu_id;
    logic [TW-1:0]   arb_done_tag;
    logic [N-1:0]    arb_slot_busy;
    logic            arb_overflow;

    wf_done_arbiter #(.NUMBER_CU(N), .CU_ID_WIDTH(IW), .TAG_WIDTH(TW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .cu2dispatch_wf_done     (done),
        .cu2dispatch_wf_tag_done (tags),
        .arb_done_valid          (arb_done_valid),
        .arb_done_cu_id          (arb_done_cu_id),
        .arb_done_tag            (arb_done_tag),
        .arb_done_ready          (ready),
        .arb_slot_busy           (arb_slot_busy),
        .arb_overflow            (arb_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cu;
        logic [TW-1:0] tag;
    } exp_t;

    // Reference model state
    bit            m_v [N];
    logic [TW-1:0] m_t [N];
    int            m_rr;
    bit            m_out;
    bit            m_ovf;
    exp_t          exp_q [$];
    bit            flush_pend;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic logic [N-1:0] model_busy();
        logic [N-1:0] b;
        for (int k = 0; k < N; k++) b[k] = m_v[k];
        return b;
    endfunction

    // One clock edge of the reference: grant first (round robin from m_rr),
    // then captures into any slot that is empty after the grant.
    function automatic void model_step(input logic [N-1:0] d, input logic [N*TW-1:0] t,
                                       input logic r, input logic rs);
        bit free;
        int g;
        if (!rs) begin
            for (int k = 0; k < N; k++) begin
                m_v[k] = 1'b0;
                m_t[k] = '0;
            end
            m_rr  = 0;
            m_out = 1'b0;
            m_ovf = 1'b0;
            flush_pend = 1'b1;
            return;
        end
        free = !m_out || r;
        g = -1;
        if (free) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_rr + i) % N;
                if (g < 0 && m_v[k]) g = k;
            end
        end
        if (g >= 0) begin
            exp_q.push_back('{g, m_t[g]});
            m_v[g] = 1'b0;
            m_rr   = (g + 1) % N;
            m_out  = 1'b1;
        end else if (free) begin
            m_out = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (d[k]) begin
                if (!m_v[k]) begin
                    m_v[k] = 1'b1;
                    m_t[k] = t[k*TW +: TW];
                end else begin
`ifdef WF_DONE_ARB_OVF_CHECK_EN
                    m_ovf = 1'b1;
`endif
                end
            end
        end
    endfunction

    // One cycle: check the state the last edge produced, then drive inputs
    // for the next edge and advance the model to match.
    task automatic cyc(input logic [N-1:0] d, input logic [N*TW-1:0] t,
                       input logic r, input logic rs);
        logic rr_eff;
        @(posedge clk);
        #1;
        if (flush_pend) begin
            exp_q.delete();
            flush_pend = 1'b0;
        end
        chk("valid", 32'(arb_done_valid), 32'(m_out));
        chk("slot_busy", 32'(arb_slot_busy), 32'(model_busy()));
        chk("overflow", 32'(arb_overflow), 32'(m_ovf));
        // Ready is held low across a reset edge so the item presented
        // before reset is compared but never counted as accepted.
        rr_eff = rs ? r : 1'b0;
        done  = d;
        tags  = t;
        ready = rr_eff;
        rst   = rs;
        model_step(d, t, rr_eff, rs);
    endtask

    function automatic logic [N*TW-1:0] one_tag(input int k, input logic [TW-1:0] v);
        logic [N*TW-1:0] t;
        t = '0;
        t[k*TW +: TW] = v;
        return t;
    endfunction

    // Monitor: every presented completion must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (arb_done_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output cu=%0d tag=%0h required=none at %0t",
                             arb_done_cu_id, arb_done_tag, $time);
                end else begin
                    chk("out_cu_id", 32'(arb_done_cu_id), 32'(exp_q[0].cu));
                    chk("out_tag", 32'(arb_done_tag), 32'(exp_q[0].tag));
                    if (ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [N*TW-1:0] t;
        logic [N-1:0]    d;
        for (int k = 0; k < N; k++) begin
            m_v[k] = 1'b0;
            m_t[k] = '0;
        end
        m_rr = 0; m_out = 1'b0; m_ovf = 1'b0; flush_pend = 1'b0;
        rst = 1'b0; done = '0; tags = '0; ready = 1'b0;
        @(posedge clk);
        @(posedge clk);

        // Reset state
        cyc('0, '0, 1'b1, 1'b0);
        cyc('0, '0, 1'b1, 1'b1);
        chk("rst_cu_id", 32'(arb_done_cu_id), 32'd0);
        chk("rst_tag", 32'(arb_done_tag), 32'd0);

        // Single completion from CU 3
        cyc(8'h08, one_tag(3, 15'h1234), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc('0, '0, 1'b1, 1'b1);

        // Reset, then all CUs at once: order 0..7 from rr_ptr 0
        cyc('0, '0, 1'b1, 1'b0);
        t = '0;
        for (int k = 0; k < N; k++) t[k*TW +: TW] = TW'(16'h100 + k);
        cyc(8'hFF, t, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++) cyc('0, '0, 1'b1, 1'b1);

        // Backpressure on CU 5
        cyc(8'h20, one_tag(5, 15'h7FFF), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc('0, '0, 1'b1, 1'b1);

        // Wrap: CU 6 granted (rr_ptr -> 7) while slots 0 and 7 fill
        cyc(8'h40, one_tag(6, 15'h0606), 1'b1, 1'b1);
        t = one_tag(0, 15'h0A00) | one_tag(7, 15'h0A07);
        cyc(8'h81, t, 1'b0, 1'b1);
        cyc('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc('0, '0, 1'b1, 1'b1);
        // rr_ptr should now be 1: CU 1 must beat CU 0
        t = one_tag(0, 15'h0B00) | one_tag(1, 15'h0B01);
        cyc(8'h03, t, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc('0, '0, 1'b1, 1'b1);

        // Overflow: output held by CU 0, CU 2 pulses twice
        cyc(8'h01, one_tag(0, 15'h0055), 1'b0, 1'b1);
        cyc('0, '0, 1'b0, 1'b1);
        cyc(8'h04, one_tag(2, 15'h0011), 1'b0, 1'b1);
        cyc('0, '0, 1'b0, 1'b1);
        cyc(8'h04, one_tag(2, 15'h0022), 1'b0, 1'b1);
        cyc('0, '0, 1'b0, 1'b1);
        cyc('0, '0, 1'b0, 1'b1);
`ifdef WF_DONE_ARB_OVF_CHECK_EN
        chk("ovf_sticky", 32'(arb_overflow), 32'd1);
`else
        chk("ovf_tied", 32'(arb_overflow), 32'd0);
`endif
        for (int i = 0; i < 5; i++) cyc('0, '0, 1'b1, 1'b1);

        // Recapture on drain: CU 1 every cycle, then reset mid-stream
        cyc('0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(8'h02, one_tag(1, TW'(16'h0300 + i)), 1'b1, 1'b1);
        cyc(8'h02, one_tag(1, 15'h03FF), 1'b1, 1'b0);
        cyc('0, '0, 1'b1, 1'b1);
        chk("midrst_cu_id", 32'(arb_done_cu_id), 32'd0);
        chk("midrst_tag", 32'(arb_done_tag), 32'd0);
        t = '0;
        for (int k = 0; k < N; k++) t[k*TW +: TW] = TW'(16'h200 + k);
        cyc(8'hFF, t, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc('0, '0, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            t = '0;
            for (int k = 0; k < N; k++) t[k*TW +: TW] = TW'($urandom);
            d = N'($urandom & $urandom);
            cyc(d, t, ($urandom_range(0, 3) != 0), 1'b1);
        end

        // Drain with a bounded budget
        for (int i = 0; i < 40 && (exp_q.size() > 0 || m_out); i++) cyc('0, '0, 1'b1, 1'b1);
        cyc('0, '0, 1'b1, 1'b1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
